// File: rtl/if_fetch_controller_if.sv
// Instruction-memory request/ready channel between the fetch controller and instruction memory.
interface if_fetch_controller_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_controller.sv
// IF-stage fetch sequencer: owns the PC, drives the imem handshake, holds the fetched
// instruction for ID, honours stall and applies branch redirects with wrong-path squash.
module if_fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic                          clock,
    input  logic                          reset,
    if_fetch_controller_if.master         imem,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_target,
    output logic                          if_valid,
    output logic [31:0]                   if_pc,
    output logic [31:0]                   if_newpc,
    output logic [31:0]                   if_inst,
    output logic [3:0]                    if_inst_num
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        req_q, req_d;
    logic        valid_d;
    logic [31:0] if_pc_d, if_newpc_d, if_inst_d;
    logic [3:0]  inst_num_d;
    logic        accept_c;
    logic        outstanding_c;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;

    // A redirect always beats acceptance, so the response in a branch cycle is dropped.
    assign accept_c      = imem.imem_ready && (state_q == S_REQ) && (!if_valid || !stall)
                           && !branch_taken;
    assign outstanding_c = req_q && !imem.imem_ready;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_BOOT;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (branch_taken)          state_d = outstanding_c ? S_DROP : S_REQ;
                else if (if_valid && stall) state_d = S_HOLD;
            end
            S_HOLD: if (branch_taken || !stall) state_d = S_REQ;
            S_DROP: if (imem.imem_ready)        state_d = S_REQ;
            default: state_d = S_BOOT;
        endcase
    end

    // Next values for PC, request and the IF/ID output register
    always_comb begin
        pc_d       = pc_q;
        target_d   = branch_taken ? branch_target : target_q;
        valid_d    = if_valid;
        if_pc_d    = if_pc;
        if_newpc_d = if_newpc;
        if_inst_d  = if_inst;
        inst_num_d = if_inst_num;
        req_d      = (state_d == S_REQ) || (state_d == S_DROP);

        if (state_q == S_DROP) begin
            // Newest target wins if a second redirect lands on the completing cycle.
            if (imem.imem_ready) pc_d = branch_taken ? branch_target : target_q;
        end else if (branch_taken) begin
            if (state_d != S_DROP) pc_d = branch_target;
        end else if (accept_c) begin
            pc_d = pc_q + PC_STEP;
        end

        if (branch_taken) begin
            valid_d = 1'b0;
        end else if (accept_c) begin
            valid_d    = 1'b1;
            if_pc_d    = pc_q;
            if_newpc_d = pc_q + PC_STEP;
            if_inst_d  = imem.imem_rdata;
            inst_num_d = if_inst_num + 4'd1;
        end else if (state_q == S_REQ && if_valid && !stall && !imem.imem_ready) begin
            valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            target_q    <= 32'd0;
            req_q       <= 1'b0;
            if_valid    <= 1'b0;
            if_pc       <= 32'd0;
            if_newpc    <= 32'd0;
            if_inst     <= 32'd0;
            if_inst_num <= 4'd0;
        end else begin
            pc_q        <= pc_d;
            target_q    <= target_d;
            req_q       <= req_d;
            if_valid    <= valid_d;
            if_pc       <= if_pc_d;
            if_newpc    <= if_newpc_d;
            if_inst     <= if_inst_d;
            if_inst_num <= inst_num_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_controller.sv
// Directed bench for if_fetch_controller: reset, streaming, stall, redirects and PC wrap.
module tb_if_fetch_controller;

    logic        clock;
    logic        reset;
    logic        reset1;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_ready;

    logic        if_valid, if_valid1;
    logic [31:0] if_pc, if_newpc, if_inst, if_pc1, if_newpc1, if_inst1;
    logic [3:0]  if_inst_num, if_inst_num1;

    int checks;
    int failures;

    if_fetch_controller_if bus0 ();
    if_fetch_controller_if bus1 ();

    // Memory returns addr + 0x100 so each fetched word identifies its address.
    assign bus0.imem_ready = mem_ready;
    assign bus0.imem_rdata = bus0.imem_addr + 32'h100;
    assign bus1.imem_ready = 1'b1;
    assign bus1.imem_rdata = bus1.imem_addr + 32'h100;

    if_fetch_controller dut (
        .clock        (clock),
        .reset        (reset),
        .imem         (bus0.master),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_newpc     (if_newpc),
        .if_inst      (if_inst),
        .if_inst_num  (if_inst_num)
    );

    if_fetch_controller #(.RESET_PC(32'hFFFF_FFFE)) dut_wrap (
        .clock        (clock),
        .reset        (reset1),
        .imem         (bus1.master),
        .stall        (1'b0),
        .branch_taken (1'b0),
        .branch_target(32'd0),
        .if_valid     (if_valid1),
        .if_pc        (if_pc1),
        .if_newpc     (if_newpc1),
        .if_inst      (if_inst1),
        .if_inst_num  (if_inst_num1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        reset1        = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        mem_ready     = 1'b0;

        repeat (3) step();
        check("rst_req",   32'(bus0.imem_req), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_num",   32'(if_inst_num), 32'd0);
        check("rst_pc",    if_pc, 32'd0);
        check("rst_inst",  if_inst, 32'd0);

        reset = 1'b1;
        #1;
        check("boot_req", 32'(bus0.imem_req), 32'd0);
        step();
        check("first_req",  32'(bus0.imem_req), 32'd1);
        check("first_addr", bus0.imem_addr, 32'd0);

        // Back-to-back fetches at one per cycle
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream_valid", 32'(if_valid), 32'd1);
            check("stream_pc",    if_pc, 32'(i));
            check("stream_newpc", if_newpc, 32'(i + 1));
            check("stream_inst",  if_inst, 32'h100 + 32'(i));
            check("stream_num",   32'(if_inst_num), 32'(i + 1));
        end

        // Stall for four cycles: output register frozen, no request
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_req",  32'(bus0.imem_req), 32'd0);
            check("stall_pc",   if_pc, 32'd3);
            check("stall_inst", if_inst, 32'h103);
            check("stall_num",  32'(if_inst_num), 32'd4);
            check("stall_addr", bus0.imem_addr, 32'd4);
        end
        stall = 1'b0;
        step();
        check("resume_req",  32'(bus0.imem_req), 32'd1);
        check("resume_addr", bus0.imem_addr, 32'd4);
        step();
        check("resume_pc",   if_pc, 32'd4);
        check("resume_inst", if_inst, 32'h104);
        check("resume_num",  32'(if_inst_num), 32'd5);

        // Memory not ready: bubble, then redirect while the request is outstanding
        mem_ready = 1'b0;
        step();
        check("bubble_valid", 32'(if_valid), 32'd0);
        check("bubble_addr",  bus0.imem_addr, 32'd5);
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        check("drop_addr0", bus0.imem_addr, 32'd5);
        check("drop_req0",  32'(bus0.imem_req), 32'd1);
        step();
        check("drop_addr1", bus0.imem_addr, 32'd5);
        check("drop_num",   32'(if_inst_num), 32'd5);
        mem_ready = 1'b1;
        step();
        check("redir_addr",  bus0.imem_addr, 32'h40);
        check("redir_valid", 32'(if_valid), 32'd0);
        check("redir_num",   32'(if_inst_num), 32'd5);
        step();
        check("tgt_pc",   if_pc, 32'h40);
        check("tgt_inst", if_inst, 32'h140);
        check("tgt_num",  32'(if_inst_num), 32'd6);

        // Branch, stall and ready together: response squashed, redirect taken
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h20;
        step();
        stall        = 1'b0;
        branch_taken = 1'b0;
        check("bsr_valid", 32'(if_valid), 32'd0);
        check("bsr_addr",  bus0.imem_addr, 32'h20);
        check("bsr_num",   32'(if_inst_num), 32'd6);
        step();
        check("bsr_pc",   if_pc, 32'h20);
        check("bsr_inst", if_inst, 32'h120);
        check("bsr_num2", 32'(if_inst_num), 32'd7);

        // PC and count wrap on the second instance
        reset1 = 1'b1;
        step();
        for (int i = 1; i <= 18; i++) begin
            step();
            if (i == 1) begin
                check("wrap_pc1",    if_pc1, 32'hFFFF_FFFE);
                check("wrap_newpc1", if_newpc1, 32'hFFFF_FFFF);
            end
            if (i == 2) begin
                check("wrap_pc2",    if_pc1, 32'hFFFF_FFFF);
                check("wrap_newpc2", if_newpc1, 32'd0);
                check("wrap_addr2",  bus1.imem_addr, 32'd0);
            end
            if (i == 18) begin
                check("wrap_num",   32'(if_inst_num1), 32'd2);
                check("wrap_addr",  bus1.imem_addr, 32'h10);
                check("wrap_pc18",  if_pc1, 32'hF);
                check("wrap_inst",  if_inst1, 32'h10F);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
